fmul_share_arbiter: RTL
=======================

// Module: fmul_share_arbiter
// PURPOSE
//  Shares one 2-stage single-precision multiplier core (valid/busy handshake, result held while
//  consumer busy) among PL_REQ_N requesters. Round-robin arbitration picks one operand pair per
//  cycle, a tag FIFO records the owner of every in-flight op, and each result returns only to its
//  owner with that owner's backpressure. Sits between the issue ports and the fmul core.
// PARAMETERS
//  PL_REQ_N      4   number of requesters (2..8)
//  PL_TAG_DEPTH  4   tag FIFO entries = max in-flight ops (>= 3: core latency 2 + 1 hold)
//  PL_RES_W      65  result bundle width {sign,exp[9:0],fract[47:0],except[5:0]}
// PORTS
//  iCLOCK        in   1                 clock
//  inRESET       in   1                 reset, synchronous, active-low
//  iREQ_VALID    in   PL_REQ_N          requester i has operand pair
//  oREQ_BUSY     out  PL_REQ_N          requester i not accepted this cycle
//  iREQ_DATA_A   in   32*PL_REQ_N       operand A, requester i at [32i+31:32i]
//  iREQ_DATA_B   in   32*PL_REQ_N       operand B, same packing
//  oRES_VALID    out  PL_REQ_N          result for requester i on oRES_DATA
//  iRES_BUSY     in   PL_REQ_N          requester i cannot take result
//  oRES_DATA     out  PL_RES_W          result bundle (shared by all requesters)
//  oCORE_REQ     out  1                 issue to core
//  iCORE_BUSY    in   1                 core cannot accept
//  oCORE_DATA_A  out  32                operand A to core
//  oCORE_DATA_B  out  32                operand B to core
//  iCORE_VALID   in   1                 core result valid
//  oCORE_BUSY    out  1                 backpressure to core output
//  iCORE_DATA    in   PL_RES_W          core result bundle
//  oIDLE         out  1                 no op in flight
//  oERR          out  1                 sticky: core result with empty tag FIFO
// BEHAVIOUR
//  - One clock; reset is synchronous and active-low. On inRESET=0 at posedge: rr pointer=0, FIFO
//    empty (count=0, rd/wr ptr=0), oERR=0. Outputs after reset: oREQ_BUSY=all 1 unless granted,
//    oRES_VALID=0, oCORE_REQ=0, oIDLE=1, oERR=0. In-flight tags are discarded; core is reset on
//    the same inRESET.
//  - Grant (combinational from registered state): grant_en = !iCORE_BUSY && count<PL_TAG_DEPTH.
//    If grant_en, first i with iREQ_VALID[i] scanning ptr, ptr+1, ... (mod PL_REQ_N) is granted.
//  - oCORE_REQ=grant_en && |iREQ_VALID; oCORE_DATA_A/B = granted slice (zero when none).
//    oREQ_BUSY[i]=!(granted i). Accept of i = iREQ_VALID[i] && !oREQ_BUSY[i].
//  - On accept: push tag i, ptr <= (i+1) mod PL_REQ_N. No accept: ptr unchanged.
//  - Return: head tag h. oRES_VALID[h]=iCORE_VALID && count!=0; other bits 0.
//    oCORE_BUSY=iCORE_VALID && count!=0 && iRES_BUSY[h]. oRES_DATA=iCORE_DATA unregistered.
//  - Pop when iCORE_VALID && count!=0 && !iRES_BUSY[h]. Push+pop same cycle: count unchanged,
//    both pointers advance; both pointers wrap at PL_TAG_DEPTH.
//  - Full (count==PL_TAG_DEPTH): no grant even if a pop happens that cycle (no bypass).
//  - Empty + iCORE_VALID: oERR<=1 (sticky until reset), oCORE_BUSY=0 (result dropped).
//  - Results return strictly in issue order; the arbiter adds 0 cycles of latency each way.
//    Issue->result = core latency (2) + stall cycles.
//  - Fairness: a continuously valid requester is granted within PL_REQ_N grants.
//  - oIDLE = (count==0).
// TESTING
//  1 Reset with all iREQ_VALID=1 -> oCORE_REQ=0 during reset; first cycle after, req0 granted,
//    ptr=1.
//  2 All 4 valid continuously, no busy -> grants 0,1,2,3,0,...; results 2 cycles later with
//    oRES_VALID one-hot 0,1,2,3; 2.0*3.0 from req1 gives sign=0, exp=10'd129, fract=48'hC00000<<23.
//  3 iRES_BUSY[2]=1 with req2 result at head -> oCORE_BUSY=1, iCORE_BUSY=1, no grants; FIFO
//    fills to 4, holds; release -> in-order drain, no loss or duplication.
//  4 Only req3 valid, 10 cycles -> 10 consecutive grants to 3, oREQ_BUSY[3]=0 each cycle.
//  5 Force iCORE_VALID=1 with FIFO empty -> oERR=1 next cycle, stays 1 until inRESET=0.
//  6 inRESET=0 with 3 ops in flight -> count=0, oIDLE=1, oRES_VALID=0 after reset edge.

Source files
------------

// File: rtl/fmul_share_arbiter.sv
// Shares a single 2-stage fmul core among PL_REQ_N requesters. Requests are granted round-robin,
// a tag FIFO remembers the owner of each in-flight op, and results are steered back to their
// owner in issue order with that owner's backpressure forwarded to the core.
module fmul_share_arbiter #(
  parameter int unsigned PL_REQ_N     = 4,
  parameter int unsigned PL_TAG_DEPTH = 4,
  parameter int unsigned PL_RES_W     = 65
) (
  input  logic                    iCLOCK,
  input  logic                    inRESET,
  input  logic [PL_REQ_N-1:0]     iREQ_VALID,
  output logic [PL_REQ_N-1:0]     oREQ_BUSY,
  input  logic [32*PL_REQ_N-1:0]  iREQ_DATA_A,
  input  logic [32*PL_REQ_N-1:0]  iREQ_DATA_B,
  output logic [PL_REQ_N-1:0]     oRES_VALID,
  input  logic [PL_REQ_N-1:0]     iRES_BUSY,
  output logic [PL_RES_W-1:0]     oRES_DATA,
  output logic                    oCORE_REQ,
  input  logic                    iCORE_BUSY,
  output logic [31:0]             oCORE_DATA_A,
  output logic [31:0]             oCORE_DATA_B,
  input  logic                    iCORE_VALID,
  output logic                    oCORE_BUSY,
  input  logic [PL_RES_W-1:0]     iCORE_DATA,
  output logic                    oIDLE,
  output logic                    oERR
);

  localparam int unsigned TagW = (PL_REQ_N > 1) ? $clog2(PL_REQ_N) : 1;
  localparam int unsigned PtrW = (PL_TAG_DEPTH > 1) ? $clog2(PL_TAG_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(PL_TAG_DEPTH + 1);

  logic [TagW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            err_q, err_d;
  logic [TagW-1:0] tag_mem_q [PL_TAG_DEPTH];

  logic            grant_en;
  logic            grant_vld;
  logic [TagW-1:0] grant_idx;
  logic [TagW-1:0] head_tag;
  logic            ret_act;
  logic            head_busy;
  logic            push;
  logic            pop;

  // Round-robin scan starting at rr_ptr_q; grant is suppressed while in reset so nothing issues.
  always_comb begin
    grant_en  = inRESET && !iCORE_BUSY && (count_q < CntW'(PL_TAG_DEPTH));
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < PL_REQ_N; k++) begin
      for (int unsigned i = 0; i < PL_REQ_N; i++) begin
        if (grant_en && !grant_vld && (i == (32'(rr_ptr_q) + k) % PL_REQ_N) && iREQ_VALID[i]) begin
          grant_vld = 1'b1;
          grant_idx = TagW'(i);
        end
      end
    end
  end

  // Issue side: operand mux and per-requester busy.
  always_comb begin
    oCORE_REQ    = grant_vld;
    oCORE_DATA_A = '0;
    oCORE_DATA_B = '0;
    oREQ_BUSY    = '1;
    for (int unsigned i = 0; i < PL_REQ_N; i++) begin
      if (grant_vld && (grant_idx == TagW'(i))) begin
        oCORE_DATA_A = iREQ_DATA_A[32*i +: 32];
        oCORE_DATA_B = iREQ_DATA_B[32*i +: 32];
        oREQ_BUSY[i] = 1'b0;
      end
    end
  end

  // Return side: steer the core result to the owner at the FIFO head.
  always_comb begin
    head_tag   = tag_mem_q[rd_ptr_q];
    ret_act    = iCORE_VALID && (count_q != '0);
    oRES_VALID = '0;
    head_busy  = 1'b0;
    for (int unsigned i = 0; i < PL_REQ_N; i++) begin
      if (head_tag == TagW'(i)) begin
        oRES_VALID[i] = ret_act;
        head_busy     = iRES_BUSY[i];
      end
    end
    oCORE_BUSY = ret_act && head_busy;
    oRES_DATA  = iCORE_DATA;
    oIDLE      = (count_q == '0);
    oERR       = err_q;
  end

  // Next-state for rr pointer, tag FIFO pointers/count and the sticky error flag.
  always_comb begin
    push     = grant_vld;
    pop      = ret_act && !head_busy;
    rr_ptr_d = rr_ptr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // A result with nothing in flight has no owner; it is dropped and flagged.
    err_d    = err_q || (iCORE_VALID && (count_q == '0));
    if (push) begin
      rr_ptr_d = (grant_idx == TagW'(PL_REQ_N - 1)) ? '0 : grant_idx + TagW'(1);
      wr_ptr_d = (wr_ptr_q == PtrW'(PL_TAG_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(PL_TAG_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Tag storage; contents are only meaningful below count_q so it needs no reset.
  always_ff @(posedge iCLOCK) begin
    if (push) begin
      tag_mem_q[wr_ptr_q] <= grant_idx;
    end
  end

endmodule
